// File: rtl/shift_reg_pkg.sv
// Shared op encodings and FSM state type for the universal shift register.
package shift_reg_pkg;

   localparam logic [2:0] OP_LOAD   = 3'd0;
   localparam logic [2:0] OP_SHL    = 3'd1;
   localparam logic [2:0] OP_SHR    = 3'd2;
   localparam logic [2:0] OP_ASR    = 3'd3;
   localparam logic [2:0] OP_ROL    = 3'd4;
   localparam logic [2:0] OP_ROR    = 3'd5;
   localparam logic [2:0] OP_SHL_SI = 3'd6;
   localparam logic [2:0] OP_SHR_SI = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/shift_step.sv
// One single-bit step of the shift datapath: current value -> next value and the bit pushed out.
module shift_step
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       op,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_next,
   output logic             out_bit
);

   always_comb begin
      data_next = data;
      out_bit   = 1'b0;
      case (op)
         OP_SHL: begin
            data_next = {data[WIDTH-2:0], 1'b0};
            out_bit   = data[WIDTH-1];
         end
         OP_SHR: begin
            data_next = {1'b0, data[WIDTH-1:1]};
            out_bit   = data[0];
         end
         OP_ASR: begin
            data_next = {data[WIDTH-1], data[WIDTH-1:1]};
            out_bit   = data[0];
         end
         OP_ROL: begin
            data_next = {data[WIDTH-2:0], data[WIDTH-1]};
            out_bit   = data[WIDTH-1];
         end
         OP_ROR: begin
            data_next = {data[0], data[WIDTH-1:1]};
            out_bit   = data[0];
         end
         OP_SHL_SI: begin
            data_next = {data[WIDTH-2:0], serial_in};
            out_bit   = data[WIDTH-1];
         end
         OP_SHR_SI: begin
            data_next = {serial_in, data[WIDTH-1:1]};
            out_bit   = data[0];
         end
         default: begin
            data_next = data;
            out_bit   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Multi-step universal shift register: LOAD or N single-bit shift/rotate steps, with busy/done handshake.
//   state     | meaning
//   ST_IDLE   | waiting for start; LOAD completes here immediately
//   ST_SHIFT  | one step per clock until the step counter expires
//   ST_FINISH | single cycle; done is raised on the following edge
module universal_shift_reg
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [CNT_W-1:0] shift_amt,
   input  logic [WIDTH-1:0] data_in,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [2:0]       op_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] step_next;
   logic             step_out;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data      (data_out),
      .op        (op_q),
      .serial_in (serial_in),
      .data_next (step_next),
      .out_bit   (step_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         op_q       <= OP_LOAD;
         cnt        <= '0;
         data_out   <= '0;
         serial_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         // done trails FINISH by one edge so it is a clean registered pulse
         done <= (state == ST_FINISH);
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (op == OP_LOAD) begin
                     data_out <= data_in;
                     state    <= ST_FINISH;
                  end else if (shift_amt == '0) begin
                     state <= ST_FINISH;
                  end else begin
                     op_q  <= op;
                     cnt   <= shift_amt;
                     busy  <= 1'b1;
                     state <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               data_out   <= step_next;
               serial_out <= step_out;
               cnt        <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  busy  <= 1'b0;
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8) with a result scoreboard.
module tb_universal_shift_reg;
   import shift_reg_pkg::*;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [2:0]    op;
   logic [CW-1:0] shift_amt;
   logic [W-1:0]  data_in;
   logic          serial_in;
   logic [W-1:0]  data_out;
   logic          serial_out;
   logic          busy;
   logic          done;

   universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .shift_amt  (shift_amt),
      .data_in    (data_in),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic [7:0] data;
      logic       so;
      int         lat;
      int         busy_n;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] m_data = 8'h00;
   logic       m_so   = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // reference step written arithmetically; returns {out_bit, next}
   function automatic logic [8:0] ref_step(input logic [2:0] o, input logic [7:0] x, input logic si);
      logic [7:0] n;
      logic       b;
      case (o)
         OP_SHL:    begin n = 8'((x << 1));                 b = x[7]; end
         OP_SHR:    begin n = x >> 1;                       b = x[0]; end
         OP_ASR:    begin n = 8'($signed(x) >>> 1);         b = x[0]; end
         OP_ROL:    begin n = 8'((x << 1) | (x >> 7));      b = x[7]; end
         OP_ROR:    begin n = 8'((x >> 1) | (x << 7));      b = x[0]; end
         OP_SHL_SI: begin n = 8'((x << 1) | {7'd0, si});    b = x[7]; end
         OP_SHR_SI: begin n = 8'((x >> 1) | ({7'd0, si} << 7)); b = x[0]; end
         default:   begin n = x;                            b = 1'b0; end
      endcase
      return {b, n};
   endfunction

   task automatic cmd(input string tag, input logic [2:0] o, input int amt,
                      input logic [7:0] d, input logic [15:0] si);
      exp_t       e;
      logic [8:0] r;
      int         c;
      int         bn;
      bit         seen;
      e.tag = tag;
      if (o == OP_LOAD) begin
         m_data   = d;
         e.lat    = 1;
         e.busy_n = 0;
      end else if (amt == 0) begin
         e.lat    = 1;
         e.busy_n = 0;
      end else begin
         for (int k = 0; k < amt; k++) begin
            r      = ref_step(o, m_data, si[k]);
            m_so   = r[8];
            m_data = r[7:0];
         end
         e.lat    = amt + 1;
         e.busy_n = amt;
      end
      e.data = m_data;
      e.so   = m_so;
      sb.push_back(e);

      start     = 1'b1;
      op        = o;
      shift_amt = amt[CW-1:0];
      data_in   = d;
      serial_in = si[0];
      @(posedge clk);
      @(negedge clk);
      start   = 1'b0;
      data_in = 8'($urandom);
      c    = 0;
      bn   = 0;
      seen = 1'b0;
      if (o == OP_LOAD) chk({tag, "_load_now"}, 64'(data_out), 64'(d));
      while (c < 100 && !seen) begin
         if (busy) bn++;
         if (done) seen = 1'b1;
         else begin
            serial_in = si[c[3:0]];
            @(posedge clk);
            @(negedge clk);
            c++;
         end
      end
      chk({tag, "_done_seen"}, 64'(seen), 64'(1));
      e = sb.pop_front();
      chk({e.tag, "_data"},    64'(data_out),   64'(e.data));
      chk({e.tag, "_sout"},    64'(serial_out), 64'(e.so));
      chk({e.tag, "_latency"}, 64'(c),          64'(e.lat));
      chk({e.tag, "_busy_n"},  64'(bn),         64'(e.busy_n));
      @(posedge clk);
      @(negedge clk);
      chk({e.tag, "_done_1cyc"}, 64'(done), 64'(0));
   endtask

   initial begin
      int  dn;
      reset     = 1'b1;
      start     = 1'b0;
      op        = OP_LOAD;
      shift_amt = '0;
      data_in   = '0;
      serial_in = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_data", 64'(data_out),   64'(0));
      chk("rst_sout", 64'(serial_out), 64'(0));
      chk("rst_busy", 64'(busy),       64'(0));
      chk("rst_done", 64'(done),       64'(0));
      reset = 1'b0;
      @(negedge clk);

      cmd("load_a5", OP_LOAD, 0, 8'hA5, 16'h0);
      chk("vec_load_a5", 64'(data_out), 64'(8'hA5));
      cmd("load_81a", OP_LOAD, 0, 8'h81, 16'h0);
      cmd("shl3",     OP_SHL, 3, 8'h00, 16'h0);
      chk("vec_shl3", 64'({data_out, serial_out}), 64'({8'h08, 1'b0}));
      cmd("load_81b", OP_LOAD, 0, 8'h81, 16'h0);
      cmd("asr2",     OP_ASR, 2, 8'h00, 16'h0);
      chk("vec_asr2", 64'(data_out), 64'(8'hE0));
      cmd("load_81c", OP_LOAD, 0, 8'h81, 16'h0);
      cmd("ror1",     OP_ROR, 1, 8'h00, 16'h0);
      chk("vec_ror1", 64'({data_out, serial_out}), 64'({8'hC0, 1'b1}));
      cmd("load_00",  OP_LOAD, 0, 8'h00, 16'h0);
      cmd("shrsi4",   OP_SHR_SI, 4, 8'h00, 16'b1101);
      chk("vec_shrsi4", 64'(data_out), 64'(8'hD0));
      cmd("load_3c",  OP_LOAD, 0, 8'h3C, 16'h0);
      cmd("shl0",     OP_SHL, 0, 8'h00, 16'h0);
      cmd("rol8",     OP_ROL, 8, 8'h00, 16'h0);
      chk("vec_rol8", 64'(data_out), 64'(8'h3C));
      cmd("load_ff",  OP_LOAD, 0, 8'hFF, 16'h0);
      cmd("shl9",     OP_SHL, 9, 8'h00, 16'h0);
      chk("vec_shl9", 64'(data_out), 64'(8'h00));
      cmd("load_96",  OP_LOAD, 0, 8'h96, 16'h0);
      cmd("shr3",     OP_SHR, 3, 8'h00, 16'h0);
      cmd("rol3",     OP_ROL, 3, 8'h00, 16'h0);
      cmd("shlsi5",   OP_SHL_SI, 5, 8'h00, 16'($urandom));
      cmd("asr15",    OP_ASR, 15, 8'h00, 16'h0);

      // abort: ignored second start, then reset mid-SHIFT
      cmd("load_81d", OP_LOAD, 0, 8'h81, 16'h0);
      start     = 1'b1;
      op        = OP_SHL;
      shift_amt = 4'd5;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start   = 1'b1;
      op      = OP_LOAD;
      data_in = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("abort_mid_data", 64'(data_out), 64'(8'h04));
      chk("abort_mid_busy", 64'(busy),     64'(1));
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("abort_data", 64'(data_out),   64'(0));
      chk("abort_busy", 64'(busy),       64'(0));
      chk("abort_done", 64'(done),       64'(0));
      chk("abort_sout", 64'(serial_out), 64'(0));
      m_data = 8'h00;
      m_so   = 1'b0;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort_no_done", 64'(dn),       64'(0));
      chk("abort_hold",    64'(data_out), 64'(0));
      cmd("recover_5a", OP_LOAD, 0, 8'h5A, 16'h0);
      cmd("ror2",       OP_ROR, 2, 8'h00, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register width in bits (legal range 2..64).
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, SHALL set the width of the shift-amount field.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a command, sampled on posedge clk.
REQ-006 op  input  3  SHALL select the command: 0 LOAD, 1 SHL, 2 SHR, 3 ASR, 4 ROL, 5 ROR, 6 SHL_SI, 7 SHR_SI.
REQ-007 shift_amt  input  CNT_W  SHALL give the number of single-bit steps; captured with start.
REQ-008 data_in  input  WIDTH  SHALL be the parallel load value for LOAD.
REQ-009 serial_in  input  1  SHALL be the bit inserted on each step of SHL_SI and SHR_SI, sampled live on every step.
REQ-010 data_out  output  WIDTH  SHALL be the current register contents.
REQ-011 serial_out  output  1  SHALL be the bit shifted out on the most recent step (MSB for left ops, LSB for right ops).
REQ-012 busy  output  1  SHALL be high while a multi-step command is in progress.
REQ-013 done  output  1  SHALL pulse high for exactly one cycle when a command completes.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, FINISH.
REQ-015 In IDLE, start with op=LOAD SHALL write data_in to the register on that edge, go to FINISH, and pulse done on the next cycle.
REQ-016 In IDLE, start with a shift op and shift_amt>0 SHALL latch op and shift_amt into a step counter and enter SHIFT; busy rises on the next cycle.
REQ-017 In SHIFT, the register SHALL move one bit position per clock, and the counter SHALL decrement; on the edge the counter reaches 0 the FSM enters FINISH.
REQ-018 A command of N steps SHALL produce done exactly N+1 cycles after the start edge; busy SHALL be high for exactly N cycles.
REQ-019 SHL/SHR SHALL insert 0; ASR SHALL replicate the MSB; ROL/ROR SHALL feed back the bit shifted out; SHL_SI/SHR_SI SHALL insert serial_in.
REQ-020 shift_amt=0 with a shift op SHALL leave the register unchanged, skip SHIFT, and pulse done one cycle later.
REQ-021 shift_amt>WIDTH SHALL be executed literally (e.g. SHL by WIDTH+1 yields 0; ROL by WIDTH returns the original value).
REQ-022 start while busy or in FINISH SHALL be ignored with no side effect; no queuing.
REQ-023 FINISH SHALL last one cycle, assert done, and return to IDLE; a start in the cycle after FINISH SHALL be accepted.
REQ-024 data_out SHALL hold its value whenever no LOAD or step occurs.

Reset
REQ-025 reset SHALL force state IDLE, data_out=0, serial_out=0, busy=0, done=0, and counter=0 on the next posedge clk.
REQ-026 reset SHALL take priority over start; asserted mid-SHIFT it SHALL abort the command with no done pulse.

Structure
REQ-027 Op encodings and the FSM state enum SHALL live in shared package shift_reg_pkg.
REQ-028 The single-step datapath (register, op, serial_in -> next value, out bit) SHALL be combinational sub-module shift_step, instanced once.
REQ-029 All outputs SHALL be driven directly from registers.

Verification
REQ-030 LOAD 8'hA5 -> data_out=8'hA5 on the edge after start, done pulse 1 cycle later, busy never high.
REQ-031 Load 8'h81, SHL amt 3 -> busy 3 cycles, data_out 8'h08, serial_out=0 (last out bit), done at start+4.
REQ-032 Load 8'h81, ASR amt 2 -> 8'hE0; ROR amt 1 from 8'h81 -> 8'hC0, serial_out=1.
REQ-033 Load 8'h00, SHR_SI amt 4, serial_in 1,0,1,1 per step -> 8'hD0.
REQ-034 Start SHL amt 5, pulse a second start in cycle 2 -> second ignored; assert reset in cycle 3 -> data_out=0, busy=0, no done.
REQ-035 SHL amt 0 on 8'h3C -> data_out unchanged, done at start+1; ROL amt 8 on 8'h3C -> 8'h3C.
